// File: rtl/pipeline_dbg_pkg.sv
// Shared encodings for the pipeline run/halt/step controller.
package pipeline_dbg_pkg;

  localparam int unsigned PIPE_DEPTH_DEF = 5;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DRAIN  = 2'd3
  } run_state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HOST  = 2'd1;
  localparam logic [1:0] CAUSE_BREAK = 2'd2;
  localparam logic [1:0] CAUSE_STEP  = 2'd3;

endpackage

// File: rtl/dbg_down_counter.sv
// Loadable down counter with a registered "count is one" flag; stops at zero.
module dbg_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_one
);

  logic [W-1:0] count;

  // is_one tracks the value count will hold, so it is ready in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      is_one <= 1'b0;
    end else if (load) begin
      count  <= load_val;
      is_one <= (load_val == W'(1));
    end else if (dec && (count != '0)) begin
      count  <= count - W'(1);
      is_one <= (count == W'(2));
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/halt/single-step controller: gates the pipeline stage enable, drains
// in-flight instructions on a halt, and keeps cycle/retire counters.
module pipeline_run_ctrl
  import pipeline_dbg_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned CNT_W      = 32,
  parameter bit          AUTO_RUN   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              cmd_ready,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       if_pc,
  input  logic              wb_valid,
  input  logic              cnt_clr,
  output logic              pipe_en,
  output logic              fetch_hold,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int unsigned        DRAIN_W     = $clog2(PIPE_DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LEN   = DRAIN_W'(PIPE_DEPTH - 1);
  localparam run_state_e         RESET_STATE = AUTO_RUN ? ST_RUN : ST_HALTED;

  run_state_e        state_q, state_d;
  logic              bp_skip;
  logic              step_one, drain_one;
  logic              cmd_acc_c, bp_match_c, bp_hit_c, halt_cmd_c;
  logic              step_load_c, drain_load_c, cause_we_c;
  logic [1:0]        cause_d;
  logic [STEP_W-1:0] step_arg_c;

  assign pipe_en    = (state_q != ST_HALTED);
  assign fetch_hold = (state_q == ST_DRAIN);
  assign halted     = (state_q == ST_HALTED);
  assign cmd_ready  = (state_q != ST_DRAIN);

  assign cmd_acc_c  = cmd_valid && cmd_ready;
  assign halt_cmd_c = cmd_acc_c && (cmd_op == OP_HALT);
  assign bp_match_c = (if_pc == bp_addr);
  assign bp_hit_c   = bp_en && bp_match_c && !bp_skip;
  assign step_arg_c = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;

  always_ff @(posedge clock) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Next state plus the load/cause strobes that accompany each transition
  always_comb begin
    state_d      = state_q;
    step_load_c  = 1'b0;
    drain_load_c = 1'b0;
    cause_we_c   = 1'b0;
    cause_d      = CAUSE_NONE;
    case (state_q)
      ST_HALTED: begin
        if (cmd_acc_c && (cmd_op == OP_RUN)) begin
          state_d = ST_RUN;
        end else if (cmd_acc_c && (cmd_op == OP_STEP)) begin
          state_d     = ST_STEP;
          step_load_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (bp_hit_c) begin
          state_d      = ST_DRAIN;
          drain_load_c = 1'b1;
          cause_we_c   = 1'b1;
          cause_d      = CAUSE_BREAK;
        end else if (halt_cmd_c) begin
          state_d      = ST_DRAIN;
          drain_load_c = 1'b1;
          cause_we_c   = 1'b1;
          cause_d      = CAUSE_HOST;
        end
      end
      ST_STEP: begin
        if (halt_cmd_c) begin
          state_d      = ST_DRAIN;
          drain_load_c = 1'b1;
          cause_we_c   = 1'b1;
          cause_d      = CAUSE_HOST;
        end else if (step_one) begin
          state_d    = ST_HALTED;
          cause_we_c = 1'b1;
          cause_d    = CAUSE_STEP;
        end
      end
      ST_DRAIN: begin
        if (drain_one) state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  dbg_down_counter #(.W(STEP_W)) u_step_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (step_load_c),
    .load_val (step_arg_c),
    .dec      (state_q == ST_STEP),
    .is_one   (step_one)
  );

  dbg_down_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (drain_load_c),
    .load_val (DRAIN_LEN),
    .dec      (state_q == ST_DRAIN),
    .is_one   (drain_one)
  );

  always_ff @(posedge clock) begin
    if (reset)           halt_cause <= CAUSE_NONE;
    else if (cause_we_c) halt_cause <= cause_d;
  end

  // Resuming at the breakpoint PC must not re-trigger until fetch moves off it
  always_ff @(posedge clock) begin
    if (reset)
      bp_skip <= 1'b0;
    else if ((state_q == ST_HALTED) && cmd_acc_c && (cmd_op == OP_RUN))
      bp_skip <= bp_match_c;
    else if ((state_q == ST_RUN) && !bp_match_c)
      bp_skip <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset || cnt_clr) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else if (pipe_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (wb_valid) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed vector table, counter-wrap sequence on a
// narrow-counter instance, then randomized traffic against a behavioural model.
module tb_pipeline_run_ctrl;

  localparam int unsigned STEP_W  = 16;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned SCNT_W  = 4;
  localparam int          DEPTH   = 5;

  localparam int M_IDLE  = 0;
  localparam int M_GO    = 1;
  localparam int M_STEPS = 2;
  localparam int M_FLUSH = 3;

  logic              clock = 1'b0;
  logic              reset, cmd_valid, bp_en, wb_valid, cnt_clr;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;
  logic [31:0]       bp_addr, if_pc;
  logic              cmd_ready, pipe_en, fetch_hold, halted;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_cnt, retire_cnt;
  logic              s_cmd_ready, s_pipe_en, s_fetch_hold, s_halted;
  logic [1:0]        s_halt_cause;
  logic [SCNT_W-1:0] s_cycle_cnt, s_retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  pipeline_run_ctrl #(.PIPE_DEPTH(DEPTH), .STEP_W(STEP_W), .CNT_W(CNT_W), .AUTO_RUN(1'b1)) u_dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .bp_en(bp_en), .bp_addr(bp_addr), .if_pc(if_pc), .wb_valid(wb_valid),
    .cnt_clr(cnt_clr), .pipe_en(pipe_en), .fetch_hold(fetch_hold), .halted(halted),
    .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  pipeline_run_ctrl #(.PIPE_DEPTH(DEPTH), .STEP_W(STEP_W), .CNT_W(SCNT_W), .AUTO_RUN(1'b1)) u_small (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(s_cmd_ready), .bp_en(bp_en), .bp_addr(bp_addr), .if_pc(if_pc), .wb_valid(wb_valid),
    .cnt_clr(cnt_clr), .pipe_en(s_pipe_en), .fetch_hold(s_fetch_hold), .halted(s_halted),
    .halt_cause(s_halt_cause), .cycle_cnt(s_cycle_cnt), .retire_cnt(s_retire_cnt)
  );

  typedef struct {
    logic        rst, cv;
    logic [1:0]  op;
    logic [15:0] arg;
    logic        be;
    logic [31:0] pc;
    logic        wb, clr;
    logic        pe, fh, hl;
    logic [1:0]  cause;
    logic        rdy;
    logic [31:0] cyc, ret;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: mode plus cycles remaining in the current step/flush window
  int          m_mode, m_rem;
  logic [1:0]  m_cause;
  bit          m_skip;
  logic [31:0] m_cyc, m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int r, input int cv, input int op, input int arg, input int be,
                     input int pc, input int wb, input int clr, input int pe, input int fh,
                     input int hl, input int cause, input int rdy, input int cyc, input int ret);
    vec_t v;
    v.rst = 1'(r);  v.cv = 1'(cv);   v.op = 2'(op);   v.arg = 16'(arg); v.be = 1'(be);
    v.pc = 32'(pc); v.wb = 1'(wb);   v.clr = 1'(clr); v.pe = 1'(pe);    v.fh = 1'(fh);
    v.hl = 1'(hl);  v.cause = 2'(cause); v.rdy = 1'(rdy); v.cyc = 32'(cyc); v.ret = 32'(ret);
    tbl.push_back(v);
  endtask

  task automatic apply(input int r, input int cv, input int op, input int arg, input int be,
                       input int pc, input int wb, input int clr);
    reset = 1'(r); cmd_valid = 1'(cv); cmd_op = 2'(op); cmd_arg = 16'(arg);
    bp_en = 1'(be); if_pc = 32'(pc); wb_valid = 1'(wb); cnt_clr = 1'(clr);
  endtask

  task automatic model_tick();
    bit acc;
    if (reset) begin
      m_mode = M_GO; m_rem = 0; m_cause = 2'd0; m_skip = 1'b0; m_cyc = '0; m_ret = '0;
      return;
    end
    acc = cmd_valid && (m_mode != M_FLUSH);
    if (cnt_clr) begin
      m_cyc = '0; m_ret = '0;
    end else if (m_mode != M_IDLE) begin
      m_cyc = m_cyc + 32'd1;
      if (wb_valid) m_ret = m_ret + 32'd1;
    end
    case (m_mode)
      M_IDLE: begin
        if (acc && cmd_op == 2'b01) begin
          m_mode = M_GO; m_skip = (if_pc == bp_addr);
        end else if (acc && cmd_op == 2'b10) begin
          m_mode = M_STEPS; m_rem = (cmd_arg == 16'd0) ? 1 : int'(cmd_arg);
        end
      end
      M_GO: begin
        if (bp_en && if_pc == bp_addr && !m_skip) begin
          m_mode = M_FLUSH; m_cause = 2'd2; m_rem = DEPTH - 1;
        end else if (acc && cmd_op == 2'b11) begin
          m_mode = M_FLUSH; m_cause = 2'd1; m_rem = DEPTH - 1;
        end
        if (if_pc != bp_addr) m_skip = 1'b0;
      end
      M_STEPS: begin
        if (acc && cmd_op == 2'b11) begin
          m_mode = M_FLUSH; m_cause = 2'd1; m_rem = DEPTH - 1;
        end else begin
          m_rem--;
          if (m_rem == 0) begin m_mode = M_IDLE; m_cause = 2'd3; end
        end
      end
      default: begin
        m_rem--;
        if (m_rem == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [4:0] exp_st;
    exp_st = {m_mode != M_IDLE, m_mode == M_FLUSH, m_mode == M_IDLE, m_mode != M_FLUSH, 1'b0};
    chk({tag, ".pipe_en"},    32'(pipe_en),    32'(exp_st[4]));
    chk({tag, ".fetch_hold"}, 32'(fetch_hold), 32'(exp_st[3]));
    chk({tag, ".halted"},     32'(halted),     32'(exp_st[2]));
    chk({tag, ".cmd_ready"},  32'(cmd_ready),  32'(exp_st[1]));
    chk({tag, ".halt_cause"}, 32'(halt_cause), 32'(m_cause));
    chk({tag, ".cycle_cnt"},  cycle_cnt,       m_cyc);
    chk({tag, ".retire_cnt"}, retire_cnt,      m_ret);
    chk({tag, ".small_ctl"},  32'({s_pipe_en, s_fetch_hold, s_halted, s_cmd_ready, s_halt_cause}),
                              32'({exp_st[4:1], m_cause}));
    chk({tag, ".small_cyc"},  32'(s_cycle_cnt),  32'(m_cyc[SCNT_W-1:0]));
    chk({tag, ".small_ret"},  32'(s_retire_cnt), 32'(m_ret[SCNT_W-1:0]));
  endtask

  task automatic rcycle(input string tag, input int r, input int cv, input int op, input int arg,
                        input int be, input int pc, input int wb, input int clr);
    apply(r, cv, op, arg, be, pc, wb, clr);
    model_tick();
    @(posedge clock);
    #1;
    check_model(tag);
  endtask

  initial begin
    bp_addr = 32'h10;
    apply(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset, free run, counter clear
    add(1,0,0,0,0,0,0,0,     1,0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,0,     1,0,0,0,1,0,0);
    for (int k = 1; k <= 10; k++) add(0,0,0,0,0,0,0,0, 1,0,0,0,1,k,0);
    add(0,0,0,0,0,0,0,1,     1,0,0,0,1,0,0);
    // HALT and breakpoint together: BREAK wins, HALT offered throughout the drain
    add(0,1,3,0,1,'h10,0,0,  1,1,0,2,0,1,0);
    for (int k = 2; k <= 4; k++) add(0,1,3,0,1,'h10,0,0, 1,1,0,2,0,k,0);
    add(0,1,3,0,1,'h10,0,0,  0,0,1,2,1,5,0);
    // STEP 3 then STEP 0 (treated as 1); breakpoints ignored while stepping
    add(0,1,2,3,1,'h10,0,0,  1,0,0,2,1,5,0);
    add(0,0,0,0,1,'h10,0,0,  1,0,0,2,1,6,0);
    add(0,0,0,0,1,'h10,0,0,  1,0,0,2,1,7,0);
    add(0,0,0,0,1,'h10,0,0,  0,0,1,3,1,8,0);
    add(0,1,2,0,1,'h10,0,0,  1,0,0,3,1,8,0);
    add(0,0,0,0,1,'h10,0,0,  0,0,1,3,1,9,0);
    // Resume at the breakpoint PC without retrigger, then host halt
    add(0,1,1,0,1,'h10,0,0,  1,0,0,3,1,9,0);
    add(0,0,0,0,1,'h10,0,0,  1,0,0,3,1,10,0);
    add(0,0,0,0,1,'h14,0,0,  1,0,0,3,1,11,0);
    add(0,1,3,0,1,'h14,0,0,  1,1,0,1,0,12,0);
    add(0,0,0,0,1,'h14,0,0,  1,1,0,1,0,13,0);
    // Reset in the second drain cycle
    add(1,0,0,0,1,'h14,0,0,  1,0,0,0,1,0,0);
    // Retire counting and clear priority
    add(0,0,0,0,0,0,1,0,     1,0,0,0,1,1,1);
    add(0,0,0,0,0,0,1,1,     1,0,0,0,1,0,0);
    add(0,0,0,0,0,0,1,0,     1,0,0,0,1,1,1);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].cv, tbl[i].op, tbl[i].arg, tbl[i].be, tbl[i].pc, tbl[i].wb, tbl[i].clr);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d.pipe_en", i),    32'(pipe_en),      32'(tbl[i].pe));
      chk($sformatf("v%0d.fetch_hold", i), 32'(fetch_hold),   32'(tbl[i].fh));
      chk($sformatf("v%0d.halted", i),     32'(halted),       32'(tbl[i].hl));
      chk($sformatf("v%0d.halt_cause", i), 32'(halt_cause),   32'(tbl[i].cause));
      chk($sformatf("v%0d.cmd_ready", i),  32'(cmd_ready),    32'(tbl[i].rdy));
      chk($sformatf("v%0d.cycle_cnt", i),  cycle_cnt,         tbl[i].cyc);
      chk($sformatf("v%0d.retire_cnt", i), retire_cnt,        tbl[i].ret);
      chk($sformatf("v%0d.small_cyc", i),  32'(s_cycle_cnt),  32'(tbl[i].cyc[SCNT_W-1:0]));
    end

    // Counter wrap on the 4-bit instance, then clear alongside a retire
    rcycle("wrap_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) rcycle("wrap_run", 0, 0, 0, 0, 0, 'h20, 1, 0);
    chk("wrap.small_ret_15", 32'(s_retire_cnt), 32'd15);
    rcycle("wrap_edge", 0, 0, 0, 0, 0, 'h20, 1, 0);
    chk("wrap.small_ret_0", 32'(s_retire_cnt), 32'd0);
    chk("wrap.small_cyc_0", 32'(s_cycle_cnt),  32'd0);
    chk("wrap.wide_ret_16", retire_cnt,        32'd16);
    rcycle("wrap_clr", 0, 0, 0, 0, 0, 'h20, 1, 1);
    chk("wrap.clr_ret", retire_cnt, 32'd0);
    chk("wrap.clr_cyc", cycle_cnt,  32'd0);

    // Randomized traffic against the model
    rcycle("rnd_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      int pc_sel, pc;
      pc_sel = int'($urandom_range(0, 2));
      pc = (pc_sel == 0) ? 'h10 : (pc_sel == 1) ? 'h14 : 'h18;
      rcycle($sformatf("rnd%0d", n),
             int'($urandom_range(0, 99) == 0), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 1)), pc, int'($urandom_range(0, 1)),
             int'($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
